// File: rtl/rv_dbus_pkg.sv
// Shared types and constants for the data-bus controller and its load path.
package rv_dbus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Load/store width and signedness encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Access-fault causes
  localparam logic [1:0] MISALIGNED = 2'd0;
  localparam logic [1:0] BUS_ERR    = 2'd1;
  localparam logic [1:0] TIMEOUT    = 2'd2;

  // Byte accesses never fault; halfwords need an even address; every other
  // width code is handled as a word and needs a word-aligned address.
  function automatic logic misaligned(input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
    case (funct3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return addr_lo[0];
      default: return addr_lo != 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/rv_dbus_ctrl_if.sv
// Memory-stage request, data-bus and writeback signals of the controller.
interface rv_dbus_ctrl_if;
  logic        i_mem_read;
  logic        i_mem_write;
  logic [31:0] i_addr;
  logic [3:0]  i_mem_sel;
  logic [31:0] i_wdata;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd;
  logic        o_stall;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [3:0]  o_bus_sel;
  logic [31:0] o_bus_wdata;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;
  logic        i_bus_err;
  logic        o_load_valid;
  logic [31:0] o_load_data;
  logic [4:0]  o_load_rd;
  logic        o_err;
  logic [1:0]  o_err_cause;

  // Controller side
  modport master (
    input  i_mem_read, i_mem_write, i_addr, i_mem_sel, i_wdata, i_funct3, i_rd,
    input  i_bus_ack, i_bus_rdata, i_bus_err,
    output o_stall, o_bus_req, o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata,
    output o_load_valid, o_load_data, o_load_rd, o_err, o_err_cause
  );

  // Pipeline / slave side
  modport slave (
    output i_mem_read, i_mem_write, i_addr, i_mem_sel, i_wdata, i_funct3, i_rd,
    output i_bus_ack, i_bus_rdata, i_bus_err,
    input  o_stall, o_bus_req, o_bus_we, o_bus_addr, o_bus_sel, o_bus_wdata,
    input  o_load_valid, o_load_data, o_load_rd, o_err, o_err_cause
  );
endinterface

// File: rtl/rv_load_align.sv
// Moves the addressed byte/halfword of a bus word to bit 0 and extends it.
module rv_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  import rv_dbus_pkg::*;

  logic [31:0] shifted;

  assign shifted = rdata >> {addr_lo, 3'b000};

  // Width/sign selection; unknown codes fall through as a full word
  always_comb begin
    data = shifted;
    case (funct3)
      LB:      data = {{24{shifted[7]}}, shifted[7:0]};
      LBU:     data = {24'd0, shifted[7:0]};
      LH:      data = {{16{shifted[15]}}, shifted[15:0]};
      LHU:     data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end
endmodule

// File: rtl/rv_dbus_ctrl.sv
// Single-outstanding load/store controller between the memory stage and a
// ready/ack data bus, with misalignment, bus-error and timeout reporting.
module rv_dbus_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic            i_clk,
  input logic            i_reset_n,
  rv_dbus_ctrl_if.master bus
);
  import rv_dbus_pkg::*;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  state_t      state_next;
  logic [15:0] cnt;
  logic [29:0] addr_word;
  logic [1:0]  addr_lo;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [1:0]  cause_q;
  logic [31:0] load_data_q;
  logic [31:0] aligned;
  logic        req_in;
  logic        misal_in;
  logic        timeout_hit;
  logic        busy;

  assign req_in      = bus.i_mem_read | bus.i_mem_write;
  assign misal_in    = misaligned(bus.i_funct3, bus.i_addr[1:0]);
  // cnt holds the number of BUSY cycles already spent, so this is the last one
  assign timeout_hit = (cnt == CNT_LAST);
  assign busy        = (state == BUSY);

  rv_load_align u_align (
    .rdata   (bus.i_bus_rdata),
    .addr_lo (addr_lo),
    .funct3  (funct3_q),
    .data    (aligned)
  );

  // Bus signals come straight from the captured request and are only live in BUSY
  assign bus.o_bus_addr  = busy ? {addr_word, 2'b00} : 32'd0;
  assign bus.o_bus_sel   = busy ? sel_q : 4'd0;
  assign bus.o_bus_we    = busy & we_q;
  assign bus.o_bus_wdata = busy ? wdata_q : 32'd0;
  assign bus.o_load_data = load_data_q;
  assign bus.o_load_rd   = rd_q;
  assign bus.o_err_cause = cause_q;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  // Next state plus stall/request/strobe decode
  always_comb begin
    state_next       = state;
    bus.o_stall      = 1'b0;
    bus.o_bus_req    = 1'b0;
    bus.o_load_valid = 1'b0;
    bus.o_err        = 1'b0;
    case (state)
      IDLE: begin
        if (req_in) begin
          bus.o_stall = 1'b1;
          state_next  = misal_in ? RESP : BUSY;
        end
      end
      BUSY: begin
        bus.o_stall   = 1'b1;
        bus.o_bus_req = 1'b1;
        if (bus.i_bus_ack || timeout_hit) state_next = RESP;
      end
      RESP: begin
        // Upstream advances on this edge; its still-present request is ignored
        state_next       = IDLE;
        bus.o_load_valid = !we_q && !err_q;
        bus.o_err        = err_q;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, timeout counter and response latching
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      cnt         <= 16'd0;
      addr_word   <= 30'd0;
      addr_lo     <= 2'd0;
      funct3_q    <= 3'd0;
      rd_q        <= 5'd0;
      we_q        <= 1'b0;
      sel_q       <= 4'd0;
      wdata_q     <= 32'd0;
      err_q       <= 1'b0;
      cause_q     <= 2'd0;
      load_data_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_in) begin
            addr_word <= bus.i_addr[31:2];
            addr_lo   <= bus.i_addr[1:0];
            funct3_q  <= bus.i_funct3;
            rd_q      <= bus.i_rd;
            // A simultaneous read and write is handled as a write
            we_q      <= bus.i_mem_write;
            sel_q     <= bus.i_mem_sel;
            wdata_q   <= bus.i_wdata;
            cnt       <= 16'd0;
            err_q     <= misal_in;
            if (misal_in) cause_q <= MISALIGNED;
          end
        end
        BUSY: begin
          cnt <= cnt + 16'd1;
          // An ack on the expiry cycle still counts as a normal completion
          if (bus.i_bus_ack) begin
            err_q <= bus.i_bus_err;
            if (bus.i_bus_err)  cause_q     <= BUS_ERR;
            else if (!we_q)     load_data_q <= aligned;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            cause_q <= TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_rv_dbus_ctrl.sv
// Directed bench for rv_dbus_ctrl built with a 4-cycle bus timeout.
module tb_rv_dbus_ctrl;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  int          obs_stall, obs_busy;
  logic        obs_done, obs_valid, obs_err, obs_bwe;
  logic [1:0]  obs_cause;
  logic [31:0] obs_data, obs_baddr, obs_bwdata, obs_post_data;
  logic [3:0]  obs_bsel;
  logic [4:0]  obs_rd;
  logic        obs_post_valid, obs_post_err;

  rv_dbus_ctrl_if bus_if ();

  rv_dbus_ctrl #(.TIMEOUT_CYCLES(4)) dut (
    .i_clk     (clk),
    .i_reset_n (reset_n),
    .bus       (bus_if.master)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  task automatic idle_inputs();
    bus_if.i_mem_read  = 1'b0;
    bus_if.i_mem_write = 1'b0;
    bus_if.i_addr      = 32'd0;
    bus_if.i_mem_sel   = 4'd0;
    bus_if.i_wdata     = 32'd0;
    bus_if.i_funct3    = 3'd0;
    bus_if.i_rd        = 5'd0;
    bus_if.i_bus_ack   = 1'b0;
    bus_if.i_bus_err   = 1'b0;
    bus_if.i_bus_rdata = 32'd0;
  endtask

  // Drives one access, acks on BUSY cycle ack_cycle (0 = never), records what
  // the controller did through the response cycle and the cycle after it.
  task automatic do_access(input logic rdq, input logic wrq, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] wdata,
                           input logic [2:0] f3, input logic [4:0] rdst,
                           input int ack_cycle, input logic berr, input logic [31:0] rdata);
    obs_stall = 0; obs_busy = 0; obs_done = 1'b0;
    obs_valid = 1'b0; obs_err = 1'b0; obs_cause = 2'd0; obs_data = 32'd0; obs_rd = 5'd0;
    obs_baddr = 32'd0; obs_bsel = 4'd0; obs_bwe = 1'b0; obs_bwdata = 32'd0;
    bus_if.i_mem_read  = rdq;
    bus_if.i_mem_write = wrq;
    bus_if.i_addr      = addr;
    bus_if.i_mem_sel   = sel;
    bus_if.i_wdata     = wdata;
    bus_if.i_funct3    = f3;
    bus_if.i_rd        = rdst;
    #1;
    for (int c = 0; c < 30; c++) begin
      if (bus_if.o_stall) obs_stall++;
      if (bus_if.o_bus_req) begin
        obs_busy++;
        obs_baddr  = bus_if.o_bus_addr;
        obs_bsel   = bus_if.o_bus_sel;
        obs_bwe    = bus_if.o_bus_we;
        obs_bwdata = bus_if.o_bus_wdata;
        bus_if.i_bus_ack   = (obs_busy == ack_cycle);
        bus_if.i_bus_err   = (obs_busy == ack_cycle) ? berr : 1'b0;
        bus_if.i_bus_rdata = (obs_busy == ack_cycle) ? rdata : 32'd0;
      end
      if (!bus_if.o_stall) begin
        obs_valid = bus_if.o_load_valid;
        obs_err   = bus_if.o_err;
        obs_cause = bus_if.o_err_cause;
        obs_data  = bus_if.o_load_data;
        obs_rd    = bus_if.o_load_rd;
        obs_done  = 1'b1;
        break;
      end
      @(negedge clk); #1;
    end
    idle_inputs();
    @(negedge clk); #1;
    obs_post_valid = bus_if.o_load_valid;
    obs_post_err   = bus_if.o_err;
    obs_post_data  = bus_if.o_load_data;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    tests++; if (bus_if.o_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b want 0", bus_if.o_stall); end
    tests++; if (bus_if.o_bus_req !== 1'b0) begin fails++; $display("FAIL reset_bus_req: got %b want 0", bus_if.o_bus_req); end
    tests++;
    if ({bus_if.o_bus_we, bus_if.o_bus_addr, bus_if.o_bus_sel, bus_if.o_bus_wdata, bus_if.o_load_valid,
         bus_if.o_load_data, bus_if.o_load_rd, bus_if.o_err, bus_if.o_err_cause} !== 110'd0) begin
      fails++;
      $display("FAIL reset_outputs: got we=%b addr=%h sel=%h wdata=%h lv=%b ld=%h rd=%0d err=%b cause=%0d want all 0",
               bus_if.o_bus_we, bus_if.o_bus_addr, bus_if.o_bus_sel, bus_if.o_bus_wdata, bus_if.o_load_valid,
               bus_if.o_load_data, bus_if.o_load_rd, bus_if.o_err, bus_if.o_err_cause);
    end
    reset_n = 1'b1;
    @(negedge clk); #1;
  endtask

  task automatic test_lw();
    do_access(1'b1, 1'b0, 32'h0000_1000, 4'b1111, 32'd0, 3'b010, 5'd5, 2, 1'b0, 32'hDEAD_BEEF);
    tests++; if (!obs_done) begin fails++; $display("FAIL lw_done: no response within budget"); end
    tests++; if (obs_baddr !== 32'h0000_1000) begin fails++; $display("FAIL lw_bus_addr: got %h want 00001000", obs_baddr); end
    tests++; if (obs_bsel !== 4'b1111 || obs_bwe !== 1'b0) begin fails++; $display("FAIL lw_sel_we: got %b/%b want 1111/0", obs_bsel, obs_bwe); end
    tests++; if (obs_stall != 3) begin fails++; $display("FAIL lw_stall_cycles: got %0d want 3", obs_stall); end
    tests++; if (obs_valid !== 1'b1 || obs_err !== 1'b0) begin fails++; $display("FAIL lw_strobe: got valid=%b err=%b want 1/0", obs_valid, obs_err); end
    tests++; if (obs_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_data: got %h want deadbeef", obs_data); end
    tests++; if (obs_rd !== 5'd5) begin fails++; $display("FAIL lw_rd: got %0d want 5", obs_rd); end
    tests++; if (obs_post_valid !== 1'b0 || obs_post_data !== 32'hDEAD_BEEF) begin fails++; $display("FAIL lw_after: got valid=%b data=%h want 0/deadbeef", obs_post_valid, obs_post_data); end
  endtask

  task automatic test_sub_word();
    do_access(1'b1, 1'b0, 32'h0000_1003, 4'b1000, 32'd0, 3'b000, 5'd6, 1, 1'b0, 32'h8012_3456);
    tests++; if (obs_baddr !== 32'h0000_1000) begin fails++; $display("FAIL lb_bus_addr: got %h want 00001000", obs_baddr); end
    tests++; if (obs_valid !== 1'b1 || obs_data !== 32'hFFFF_FF80) begin fails++; $display("FAIL lb_data: got valid=%b data=%h want 1/ffffff80", obs_valid, obs_data); end
    do_access(1'b1, 1'b0, 32'h0000_1003, 4'b1000, 32'd0, 3'b100, 5'd7, 1, 1'b0, 32'h8012_3456);
    tests++; if (obs_valid !== 1'b1 || obs_data !== 32'h0000_0080) begin fails++; $display("FAIL lbu_data: got valid=%b data=%h want 1/00000080", obs_valid, obs_data); end
    do_access(1'b1, 1'b0, 32'h0000_1002, 4'b1100, 32'd0, 3'b101, 5'd8, 1, 1'b0, 32'h8001_5678);
    tests++; if (obs_valid !== 1'b1 || obs_data !== 32'h0000_8001) begin fails++; $display("FAIL lhu_data: got valid=%b data=%h want 1/00008001", obs_valid, obs_data); end
    tests++; if (obs_bsel !== 4'b1100 || obs_stall != 2) begin fails++; $display("FAIL lhu_sel_stall: got %b/%0d want 1100/2", obs_bsel, obs_stall); end
  endtask

  task automatic test_store();
    do_access(1'b0, 1'b1, 32'h0000_2000, 4'b1111, 32'h1234_5678, 3'b010, 5'd0, 1, 1'b0, 32'd0);
    tests++; if (obs_bwe !== 1'b1 || obs_bsel !== 4'b1111) begin fails++; $display("FAIL sw_we_sel: got %b/%b want 1/1111", obs_bwe, obs_bsel); end
    tests++; if (obs_bwdata !== 32'h1234_5678 || obs_baddr !== 32'h0000_2000) begin fails++; $display("FAIL sw_bus: got %h@%h want 12345678@00002000", obs_bwdata, obs_baddr); end
    tests++; if (obs_valid !== 1'b0 || obs_err !== 1'b0) begin fails++; $display("FAIL sw_strobes: got valid=%b err=%b want 0/0", obs_valid, obs_err); end
    tests++; if (obs_stall != 2) begin fails++; $display("FAIL sw_stall_cycles: got %0d want 2", obs_stall); end
    tests++; if (obs_post_data !== 32'h0000_8001) begin fails++; $display("FAIL sw_load_hold: got %h want 00008001", obs_post_data); end
    do_access(1'b1, 1'b1, 32'h0000_2004, 4'b1111, 32'hA5A5_A5A5, 3'b010, 5'd3, 1, 1'b0, 32'hFFFF_FFFF);
    tests++; if (obs_bwe !== 1'b1 || obs_valid !== 1'b0) begin fails++; $display("FAIL rdwr_as_write: got we=%b valid=%b want 1/0", obs_bwe, obs_valid); end
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 1'b0, 32'h0000_1001, 4'b0110, 32'd0, 3'b001, 5'd9, 1, 1'b0, 32'd0);
    tests++; if (obs_busy != 0) begin fails++; $display("FAIL mis_no_bus: got %0d bus_req cycles want 0", obs_busy); end
    tests++; if (obs_err !== 1'b1 || obs_cause !== 2'd0 || obs_valid !== 1'b0) begin fails++; $display("FAIL mis_err: got err=%b cause=%0d valid=%b want 1/0/0", obs_err, obs_cause, obs_valid); end
    tests++; if (obs_stall != 1 || obs_post_err !== 1'b0) begin fails++; $display("FAIL mis_stall_once: got stall=%0d err_after=%b want 1/0", obs_stall, obs_post_err); end
  endtask

  task automatic test_errors();
    do_access(1'b1, 1'b0, 32'h0000_4000, 4'b1111, 32'd0, 3'b010, 5'd10, 0, 1'b0, 32'd0);
    tests++; if (obs_busy != 4) begin fails++; $display("FAIL to_busy_cycles: got %0d want 4", obs_busy); end
    tests++; if (obs_err !== 1'b1 || obs_cause !== 2'd2 || obs_valid !== 1'b0) begin fails++; $display("FAIL to_err: got err=%b cause=%0d valid=%b want 1/2/0", obs_err, obs_cause, obs_valid); end
    do_access(1'b1, 1'b0, 32'h0000_4004, 4'b1111, 32'd0, 3'b010, 5'd11, 1, 1'b1, 32'h1111_1111);
    tests++; if (obs_err !== 1'b1 || obs_cause !== 2'd1 || obs_valid !== 1'b0) begin fails++; $display("FAIL buserr: got err=%b cause=%0d valid=%b want 1/1/0", obs_err, obs_cause, obs_valid); end
    do_access(1'b1, 1'b0, 32'h0000_4008, 4'b1111, 32'd0, 3'b010, 5'd12, 4, 1'b0, 32'hCAFE_F00D);
    tests++; if (obs_busy != 4 || obs_err !== 1'b0) begin fails++; $display("FAIL expiry_ack_err: got busy=%0d err=%b want 4/0", obs_busy, obs_err); end
    tests++; if (obs_valid !== 1'b1 || obs_data !== 32'hCAFE_F00D || obs_rd !== 5'd12) begin fails++; $display("FAIL expiry_ack_load: got valid=%b data=%h rd=%0d want 1/cafef00d/12", obs_valid, obs_data, obs_rd); end
  endtask

  task automatic test_reset_mid();
    bus_if.i_mem_read = 1'b1;
    bus_if.i_addr     = 32'h0000_3000;
    bus_if.i_mem_sel  = 4'b1111;
    bus_if.i_funct3   = 3'b010;
    bus_if.i_rd       = 5'd7;
    @(negedge clk); #1;
    tests++; if (bus_if.o_bus_req !== 1'b1) begin fails++; $display("FAIL rst_mid_busy: got bus_req=%b want 1", bus_if.o_bus_req); end
    reset_n = 1'b0;
    idle_inputs();
    @(negedge clk); #1;
    tests++; if (bus_if.o_bus_req !== 1'b0 || bus_if.o_stall !== 1'b0) begin fails++; $display("FAIL rst_mid_drop: got req=%b stall=%b want 0/0", bus_if.o_bus_req, bus_if.o_stall); end
    reset_n = 1'b1;
    @(negedge clk); #1;
    tests++; if (bus_if.o_load_valid !== 1'b0 || bus_if.o_err !== 1'b0) begin fails++; $display("FAIL rst_mid_strobes: got valid=%b err=%b want 0/0", bus_if.o_load_valid, bus_if.o_err); end
    do_access(1'b1, 1'b0, 32'h0000_3004, 4'b1111, 32'd0, 3'b010, 5'd9, 1, 1'b0, 32'h0BAD_F00D);
    tests++; if (obs_valid !== 1'b1 || obs_data !== 32'h0BAD_F00D || obs_rd !== 5'd9) begin fails++; $display("FAIL rst_mid_next: got valid=%b data=%h rd=%0d want 1/0badf00d/9", obs_valid, obs_data, obs_rd); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sub_word();
    test_store();
    test_misaligned();
    test_errors();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
